// File: rtl/cordic_serial_addsub_pkg.sv
// Shared types and defaults for the CORDIC digit-serial add/sub unit.
// Holds state encodings and default WIDTH/DIGIT constants.
package cordic_serial_addsub_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DIGIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter width for n digit cycles; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cordic_serial_addsub_if.sv
// Operand/result handshake bundle for cordic_serial_addsub.
// master drives operands and out_ready; slave is the adder.
interface cordic_serial_addsub_if
    import cordic_serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, ovf
    );

endinterface

// File: rtl/cordic_digit_adder.sv
// DIGIT-bit ripple adder of majority-carry / XOR-sum cells.
// Also exposes the carry into the top bit for overflow detection.
module cordic_digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             c_i,
    output logic [DIGIT-1:0] s_o,
    output logic             c_o,
    output logic             c_top_o
);

    logic [DIGIT:0] c;

    // Ripple the carry through each bit cell.
    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = c_i;
        for (int i = 0; i < DIGIT; i++) begin
            s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]  = (a_i[i] & b_i[i])
                    | (a_i[i] & c[i])
                    | (b_i[i] & c[i]);
        end
    end

    assign c_o     = c[DIGIT];
    assign c_top_o = c[DIGIT-1];

endmodule

// File: rtl/cordic_serial_addsub.sv
// Digit-serial two's complement add/sub, DIGIT bits per clock.
// Optional macro CORDIC_ADDSUB_SAT_EN clamps the result on overflow.
module cordic_serial_addsub
    import cordic_serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input logic                  clk,
    input logic                  rst,
    cordic_serial_addsub_if.slave bus
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_w(N);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] dig_s;
    logic             dig_c;
    logic             dig_ctop;
    logic             last;
    logic             ovf_now;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] res_fin;

    cordic_digit_adder #(
        .DIGIT (DIGIT)
    ) u_add (
        .a_i     (a_q[DIGIT-1:0]),
        .b_i     (b_q[DIGIT-1:0]),
        .c_i     (carry_q),
        .s_o     (dig_s),
        .c_o     (dig_c),
        .c_top_o (dig_ctop)
    );

    // New digit enters the result from the top; older digits move down.
    assign res_next = (res_q >> DIGIT)
                    | (WIDTH'(dig_s) << (WIDTH - DIGIT));
    assign last     = (cnt_q == CW'(N - 1));
    assign ovf_now  = dig_ctop ^ dig_c;

`ifdef CORDIC_ADDSUB_SAT_EN
    // On overflow clamp to the extreme matching A's sign (top digit of a_q).
    always_comb begin
        res_fin = res_next;
        if (ovf_now) begin
            if (a_q[DIGIT-1]) begin
                res_fin = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                res_fin = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
    end
`else
    assign res_fin = res_next;
`endif

    // Next-state and datapath update for IDLE/RUN/DONE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        carry_d     = carry_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    state_d    = ST_RUN;
                    a_d        = bus.a;
                    b_d        = bus.sub ? ~bus.b : bus.b;
                    carry_d    = bus.sub;
                    cnt_d      = '0;
                    res_d      = '0;
                    in_ready_d = 1'b0;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dig_c;
                res_d   = res_next;
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    state_d     = ST_DONE;
                    cnt_d       = '0;
                    sum_d       = res_fin;
                    cout_d      = dig_c;
                    ovf_d       = ovf_now;
                    out_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_cordic_serial_addsub.sv
// Directed bench for cordic_serial_addsub (DIGIT=4 and DIGIT=WIDTH).
// Expected values are hand-computed; saturation values follow CORDIC_ADDSUB_SAT_EN.
module tb_cordic_serial_addsub;

`ifdef CORDIC_ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cordic_serial_addsub_if #(.WIDTH(16)) bus ();
    cordic_serial_addsub_if #(.WIDTH(16)) bus1 ();

    assign bus1.in_valid  = bus.in_valid;
    assign bus1.a         = bus.a;
    assign bus1.b         = bus.b;
    assign bus1.sub       = bus.sub;
    assign bus1.out_ready = bus.out_ready;

    cordic_serial_addsub #(
        .WIDTH (16),
        .DIGIT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cordic_serial_addsub #(
        .WIDTH (16),
        .DIGIT (16)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] r_sum, r1_sum;
    logic        r_c, r_v, r1_c, r1_v;
    int          r_lat, r1_lat;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] ta,
                          input logic [15:0] tb_,
                          input logic        ts,
                          input int          hold);
        bit done;
        check("acc_rdy", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.a        = ta;
        bus.b        = tb_;
        bus.sub      = ts;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        r_lat  = 0;
        r1_lat = 0;
        done   = 1'b0;
        for (int i = 1; i <= 20 && !done; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus1.out_valid && r1_lat == 0) begin
                r1_lat = i;
                r1_sum = bus1.sum;
                r1_c   = bus1.carry_out;
                r1_v   = bus1.ovf;
            end
            if (bus.out_valid) begin
                r_lat = i;
                done  = 1'b1;
            end
        end
        r_sum = bus.sum;
        r_c   = bus.carry_out;
        r_v   = bus.ovf;
        if (hold > 0) begin
            bus.out_ready = 1'b0;
            repeat (hold) begin
                @(posedge clk);
                @(negedge clk);
                check("hold_sum", bus.sum, r_sum);
                check("hold_cout", bus.carry_out, r_c);
                check("hold_ovf", bus.ovf, r_v);
                check("hold_vld", bus.out_valid, 1);
                check("hold_rdy", bus.in_ready, 0);
            end
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check("rel_rdy", bus.in_ready, 1);
        check("rel_vld", bus.out_valid, 0);
    endtask

    task automatic check_res(input string       tag,
                             input logic [15:0] es,
                             input logic        ec,
                             input logic        ev);
        check({tag, "_lat"}, r_lat, 4);
        check({tag, "_sum"}, r_sum, es);
        check({tag, "_cout"}, r_c, ec);
        check({tag, "_ovf"}, r_v, ev);
        check({tag, "_n1_lat"}, r1_lat, 1);
        check({tag, "_n1_sum"}, r1_sum, es);
        check({tag, "_n1_cout"}, r1_c, ec);
        check({tag, "_n1_ovf"}, r1_v, ev);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", bus.in_ready, 1);
        check("rst_vld", bus.out_valid, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_cout", bus.carry_out, 0);
        check("rst_ovf", bus.ovf, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(16'h1234, 16'h0FCD, 1'b0, 0);
        check_res("add", 16'h2201, 1'b0, 1'b0);

        run_op(16'h0005, 16'h0007, 1'b1, 0);
        check_res("borrow", 16'hFFFE, 1'b0, 1'b0);

        run_op(16'h7FFF, 16'h0001, 1'b0, 0);
        check_res("povf", SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1);

        run_op(16'h8000, 16'h0001, 1'b1, 3);
        check_res("novf", SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b0 | 1'b1);

        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        check_res("wrap", 16'h0000, 1'b1, 1'b0);

        bus.in_valid = 1'b1;
        bus.a        = 16'h1111;
        bus.b        = 16'h2222;
        bus.sub      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mrst_vld", bus.out_valid, 0);
        check("mrst_rdy", bus.in_ready, 1);
        check("mrst_sum", bus.sum, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("mrst_no_vld", bus.out_valid, 0);

        run_op(16'h0010, 16'h0020, 1'b0, 0);
        check_res("post_rst", 16'h0030, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
